mul_accum64: RTL and testbench

- Sequential multiply-accumulate back end that sits directly downstream of the 32x32 radix-8 Booth multiplier and its 64-bit CLA.
- Consumes one signed 64-bit product per accepted beat and sums the products of a packet into a signed accumulator. A packet is a dot product terminated by in_last.
- Presents the registered sum with overflow and term-count status on a valid/ready output port.
- Gives the combinational multiplier a registered, flow-controlled consumer.

---
 rtl/mul_accum64.sv | 95 +++++++++
 tb/tb_mul_accum64.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_accum64.sv
// Multiply-accumulate back end: sums signed 64-bit products of a packet into a
// signed accumulator and presents the registered result on a valid/ready port.
module mul_accum64 #(
   parameter int ACC_W = 64,
   parameter bit SAT   = 1'b1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_product,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [ACC_W-1:0] acc, prod_ext, sum, acc_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic             ovf, add_ovf, accept;

   assign prod_ext = ACC_W'($signed(in_product));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ACCUM;
      else        state <= state_nxt;
   end

   // in_ready is gated by rst_n so no beat is taken while reset is held
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = rst_n;
            accept   = in_valid & rst_n;
            if (accept && in_last) state_nxt = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
   end

   // Signed overflow: equal addend signs, sum sign differs; clamp by addend sign
   always_comb begin
      sum     = acc + prod_ext;
      add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
      acc_nxt = sum;
      if (SAT && add_ovf) begin
         if (prod_ext[ACC_W-1]) acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
         else                   acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
      end
      count_nxt = (count == '1) ? count : count + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc       <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         out_acc   <= '0;
         out_ovf   <= 1'b0;
         out_count <= '0;
      end else if (accept) begin
         acc   <= acc_nxt;
         count <= count_nxt;
         ovf   <= ovf | add_ovf;
         if (in_last) begin
            out_acc   <= acc_nxt;
            out_ovf   <= ovf | add_ovf;
            out_count <= count_nxt;
         end
      end else if (state == HOLD && out_ready) begin
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_accum64.sv
// Bench for mul_accum64: three configurations share one stimulus stream and are
// checked every cycle against a packet-level arithmetic model.
module tb_mul_accum64;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_last, out_ready;
   logic [63:0] in_product;

   logic        rdy [3];
   logic        vld [3];
   logic [63:0] acc_o [3];
   logic        ovf_o [3];
   logic [7:0]  cnt_a, cnt_b;
   logic [1:0]  cnt_c;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   mul_accum64 #(.ACC_W(64), .SAT(1'b1), .CNT_W(8)) u_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_product(in_product), .in_last(in_last), .out_valid(vld[0]),
      .out_ready(out_ready), .out_acc(acc_o[0]), .out_ovf(ovf_o[0]), .out_count(cnt_a));

   mul_accum64 #(.ACC_W(64), .SAT(1'b0), .CNT_W(8)) u_s0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_product(in_product), .in_last(in_last), .out_valid(vld[1]),
      .out_ready(out_ready), .out_acc(acc_o[1]), .out_ovf(ovf_o[1]), .out_count(cnt_b));

   mul_accum64 #(.ACC_W(64), .SAT(1'b1), .CNT_W(2)) u_c2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
      .in_product(in_product), .in_last(in_last), .out_valid(vld[2]),
      .out_ready(out_ready), .out_acc(acc_o[2]), .out_ovf(ovf_o[2]), .out_count(cnt_c));

   function automatic logic [63:0] cnt_v(input int k);
      case (k)
         0:       return 64'(cnt_a);
         1:       return 64'(cnt_b);
         default: return 64'(cnt_c);
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      nvec++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   // ---------------- packet-level model ----------------
   bit                 sat_cfg [3] = '{1'b1, 1'b0, 1'b1};
   int                 cw_cfg  [3] = '{8, 8, 2};
   logic signed [63:0] pkt [$];
   logic [63:0]        exp_acc [3];
   bit                 exp_ovf [3];
   int                 exp_cnt [3];
   bit                 exp_hold = 1'b0;
   bit                 started  = 1'b0;
   logic [63:0]        m_acc;
   bit                 m_ovf;
   int                 m_cnt;

   // Exact-range arithmetic: overflow is a true sum outside the 64-bit signed range
   task automatic model(input int k, output logic [63:0] r_acc, output bit r_ovf, output int r_cnt);
      logic signed [63:0] a;
      logic signed [65:0] s, mx, mn;
      int cap;
      mx = '0; mx[62:0] = '1;
      mn = '1; mn[62:0] = '0;
      a = '0; r_ovf = 1'b0;
      foreach (pkt[i]) begin
         s = a + pkt[i];
         if (s > mx || s < mn) begin
            r_ovf = 1'b1;
            if (sat_cfg[k]) a = (s > mx) ? mx[63:0] : mn[63:0];
            else            a = s[63:0];
         end else begin
            a = s[63:0];
         end
      end
      r_acc = a;
      cap   = (1 << cw_cfg[k]) - 1;
      r_cnt = (pkt.size() > cap) ? cap : pkt.size();
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         pkt.delete();
         exp_hold <= 1'b0;
         started  <= 1'b1;
      end else if (!exp_hold) begin
         if (in_valid) begin
            pkt.push_back(in_product);
            if (in_last) begin
               for (int k = 0; k < 3; k++) begin
                  model(k, m_acc, m_ovf, m_cnt);
                  exp_acc[k] <= m_acc;
                  exp_ovf[k] <= m_ovf;
                  exp_cnt[k] <= m_cnt;
               end
               pkt.delete();
               exp_hold <= 1'b1;
            end
         end
      end else if (out_ready) begin
         exp_hold <= 1'b0;
      end
   end

   always begin
      @(negedge clk);
      #1;
      if (started) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("in_ready[%0d]", k), 64'(rdy[k]), 64'(rst_n && !exp_hold));
            chk($sformatf("out_valid[%0d]", k), 64'(vld[k]), 64'(exp_hold));
            if (exp_hold) begin
               chk($sformatf("out_acc[%0d]", k), acc_o[k], exp_acc[k]);
               chk($sformatf("out_ovf[%0d]", k), 64'(ovf_o[k]), 64'(exp_ovf[k]));
               chk($sformatf("out_count[%0d]", k), cnt_v(k), 64'(exp_cnt[k]));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [63:0] p, input bit last);
      int n = 0;
      in_valid = 1'b1; in_product = p; in_last = last;
      forever begin
         #1;
         if (rdy[0]) break;
         if (n == 20) begin
            nvec++; nerr++;
            $display("FAIL send_timeout: in_ready never rose for beat %h", p);
            break;
         end
         n++;
         @(negedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_product = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(vld[0]), 64'd0);
      chk("rst_acc", acc_o[0], 64'd0);
      chk("rst_ready", 64'(rdy[0]), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // basic sum with a bubble
      send(64'd5, 1'b0);
      @(negedge clk);
      send(-64'sd3, 1'b0);
      send(64'd10, 1'b1);
      chk("basic_latency", 64'(vld[0]), 64'd1);
      chk("basic_acc", acc_o[0], 64'd12);
      chk("basic_cnt", cnt_v(0), 64'd3);
      chk("basic_ovf", 64'(ovf_o[0]), 64'd0);
      release_out();

      // positive overflow: saturate vs wrap
      send(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
      send(64'd1, 1'b1);
      chk("sat_pos_acc", acc_o[0], 64'h7FFF_FFFF_FFFF_FFFF);
      chk("sat_pos_ovf", 64'(ovf_o[0]), 64'd1);
      chk("sat_pos_cnt", cnt_v(0), 64'd2);
      chk("wrap_acc", acc_o[1], 64'h8000_0000_0000_0000);
      chk("wrap_ovf", 64'(ovf_o[1]), 64'd1);
      release_out();

      // single beat, ovf must be cleared
      send(64'd7, 1'b1);
      chk("single_acc", acc_o[1], 64'd7);
      chk("single_ovf", 64'(ovf_o[1]), 64'd0);
      chk("single_cnt", cnt_v(1), 64'd1);
      release_out();

      // negative overflow
      send(64'h8000_0000_0000_0000, 1'b0);
      send(-64'sd1, 1'b1);
      chk("sat_neg_acc", acc_o[0], 64'h8000_0000_0000_0000);
      chk("sat_neg_ovf", 64'(ovf_o[0]), 64'd1);
      chk("wrap_neg_acc", acc_o[1], 64'h7FFF_FFFF_FFFF_FFFF);
      release_out();

      // mixed negatives
      send(-64'sd100, 1'b0);
      send(-64'sd200, 1'b0);
      @(negedge clk);
      send(64'd50, 1'b1);
      chk("neg_acc", acc_o[0], -64'sd250);
      release_out();

      // backpressure: result held, beats ignored
      send(64'd3, 1'b0);
      send(64'd4, 1'b1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_product = 64'(1000 + i); in_last = i[0];
         @(negedge clk);
         chk("bp_valid", 64'(vld[0]), 64'd1);
         chk("bp_acc", acc_o[0], 64'd7);
         chk("bp_cnt", cnt_v(0), 64'd2);
         chk("bp_ready", 64'(rdy[0]), 64'd0);
      end
      in_valid = 1'b0; in_last = 1'b0;
      release_out();
      chk("bp_rel_valid", 64'(vld[0]), 64'd0);
      chk("bp_rel_ready", 64'(rdy[0]), 64'd1);

      // count saturation
      for (int i = 0; i < 5; i++) send(64'd1, i == 4);
      chk("cnt2_cnt", cnt_v(2), 64'd3);
      chk("cnt2_acc", acc_o[2], 64'd5);
      chk("cnt8_cnt", cnt_v(0), 64'd5);
      release_out();

      // reset mid-packet
      send(64'd100, 1'b0);
      send(64'd200, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 64'(vld[0]), 64'd0);
      chk("midrst_ready", 64'(rdy[0]), 64'd0);
      rst_n = 1'b1;
      send(64'd9, 1'b1);
      chk("midrst_acc", acc_o[0], 64'd9);
      chk("midrst_cnt", cnt_v(0), 64'd1);
      chk("midrst_ovf", 64'(ovf_o[0]), 64'd0);
      release_out();
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
